// File: rtl/timer_counter.sv
// Count engine of the timer: prescaled tick, up/down count between 0 and MAX
// with clear/load/stop/start control, registered value/running/done outputs.
module timer_counter #(
   parameter int DIV = 50_000_000,
   parameter int MAX = 999
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       stop,
   input  logic       clear,
   input  logic       load,
   input  logic [9:0] load_value,
   input  logic       dir,
   output logic [9:0] value,
   output logic       running,
   output logic       done
);

   localparam int PW = $clog2(DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
   localparam logic [9:0]    MAX_V      = 10'(MAX);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_PAUSE,
      S_DONE
   } state_t;

   state_t          r_state;
   logic [9:0]      r_value;
   logic [PW-1:0]   r_presc;
   logic            r_done;
   logic            r_running;

   state_t          w_nextState;
   logic [9:0]      w_nextValue;
   logic [PW-1:0]   w_nextPresc;
   logic            w_nextDone;
   logic            w_atTerminal;
   logic [9:0]      w_valueUp;
   logic [9:0]      w_valueDn;

   assign w_atTerminal = dir ? (r_value == 10'd0) : (r_value == MAX_V);
   assign w_valueUp    = r_value + 10'd1;
   assign w_valueDn    = r_value - 10'd1;

   // stop outranks start even when stop itself has nothing to do
   always_comb begin
      w_nextState = r_state;
      w_nextValue = r_value;
      w_nextPresc = r_presc;
      w_nextDone  = 1'b0;
      if (clear) begin
         w_nextState = S_IDLE;
         w_nextValue = '0;
         w_nextPresc = '0;
      end else if (load) begin
         w_nextState = S_IDLE;
         w_nextValue = (load_value > MAX_V) ? MAX_V : load_value;
         w_nextPresc = '0;
      end else if (stop) begin
         if (r_state == S_RUN) begin
            w_nextState = S_PAUSE;
         end
      end else if (start && (r_state != S_RUN)) begin
         if (r_state == S_PAUSE) begin
            w_nextState = S_RUN;
         end else if (w_atTerminal) begin
            w_nextState = S_DONE;
            w_nextDone  = 1'b1;
         end else begin
            w_nextState = S_RUN;
            w_nextPresc = '0;
         end
      end else if (r_state == S_RUN) begin
         if (r_presc == PRESC_LAST) begin
            w_nextPresc = '0;
            if (w_atTerminal) begin
               w_nextState = S_DONE;
               w_nextDone  = 1'b1;
            end else if (dir) begin
               w_nextValue = w_valueDn;
               if (w_valueDn == 10'd0) begin
                  w_nextState = S_DONE;
                  w_nextDone  = 1'b1;
               end
            end else begin
               w_nextValue = w_valueUp;
               if (w_valueUp == MAX_V) begin
                  w_nextState = S_DONE;
                  w_nextDone  = 1'b1;
               end
            end
         end else begin
            w_nextPresc = r_presc + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_value   <= '0;
         r_presc   <= '0;
         r_done    <= 1'b0;
         r_running <= 1'b0;
      end else begin
         r_state   <= w_nextState;
         r_value   <= w_nextValue;
         r_presc   <= w_nextPresc;
         r_done    <= w_nextDone;
         r_running <= (w_nextState == S_RUN);
      end
   end

   assign value   = r_value;
   assign running = r_running;
   assign done    = r_done;

endmodule
